// File: rtl/vga_pixel_prefetch.sv
// Raster-order pixel prefetcher: fetches framebuffer words over a req/ack port into a
// first-word-fall-through FIFO that the VGA output stage drains one pixel per clock.
module vga_pixel_prefetch #(
    parameter int H_VISIBLE_AREA = 800,
    parameter int V_VISIBLE_AREA = 600,
    parameter int PIXEL_WIDTH    = 12,
    parameter int ADDR_WIDTH     = 19,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                          VGA_CLK,
    input  logic                          RESET_N,
    input  logic                          FRAME_START,
    output logic                          MEM_REQ,
    output logic [ADDR_WIDTH-1:0]         MEM_ADDR,
    input  logic                          MEM_ACK,
    input  logic [PIXEL_WIDTH-1:0]        MEM_DATA,
    input  logic                          PIX_READY,
    output logic                          PIX_VALID,
    output logic [PIXEL_WIDTH-1:0]        PIX_DATA,
    output logic [$clog2(FIFO_DEPTH):0]   LEVEL,
    output logic                          FETCH_DONE,
    output logic                          UNDERFLOW
);
    // state   | meaning
    // IDLE    | no request outstanding; waits for FIFO room and pixels left in the frame
    // REQ     | MEM_REQ high at MEM_ADDR; each ack pushes a pixel
    // DISCARD | frame restarted under an open request; wait for its ack and drop the data

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [ADDR_WIDTH:0] TOTAL   = (ADDR_WIDTH+1)'(H_VISIBLE_AREA * V_VISIBLE_AREA);
    localparam logic [LVL_W-1:0]    DEPTH_L = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH:0]     cnt_q, cnt_d, cnt_inc;
    logic                    done_q, done_d;
    logic                    uf_q, uf_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]        level_q, level_d, level_next;
    logic [PIXEL_WIDTH-1:0]  fifo_q [FIFO_DEPTH];
    logic                    valid, push, pop;

    assign valid      = (level_q != '0);
    assign push       = MEM_ACK && (state_q == REQ) && !FRAME_START;
    assign pop        = PIX_READY && valid && !FRAME_START;
    assign cnt_inc    = cnt_q + (ADDR_WIDTH+1)'(1);
    assign level_next = level_q + LVL_W'(push) - LVL_W'(pop);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        done_d   = done_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        level_d  = level_next;
        uf_d     = uf_q | (PIX_READY & ~valid);

        unique case (state_q)
            IDLE: begin
                if ((level_q < DEPTH_L) && !done_q) state_d = REQ;
            end
            REQ: begin
                if (MEM_ACK) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TOTAL) begin
                        // last pixel: address parks on the final word
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        addr_d = addr_q + ADDR_WIDTH'(1);
                        if (!(level_next < DEPTH_L)) state_d = IDLE;
                    end
                end
            end
            DISCARD: begin
                if (MEM_ACK) begin
                    state_d = IDLE;
                    addr_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (FRAME_START) begin
            level_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            done_d   = 1'b0;
            // an open request cannot be withdrawn, so keep its address until acked
            if ((state_q != IDLE) && !MEM_ACK) begin
                state_d = DISCARD;
                addr_d  = addr_q;
            end else begin
                state_d = IDLE;
                addr_d  = '0;
            end
        end
    end

    always_ff @(posedge VGA_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            uf_q     <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            uf_q     <= uf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge VGA_CLK) begin
        if (push) fifo_q[wr_ptr_q] <= MEM_DATA;
    end

    assign MEM_REQ    = (state_q != IDLE);
    assign MEM_ADDR   = addr_q;
    assign PIX_VALID  = valid;
    assign PIX_DATA   = valid ? fifo_q[rd_ptr_q] : '0;
    assign LEVEL      = level_q;
    assign FETCH_DONE = done_q;
    assign UNDERFLOW  = uf_q;
endmodule
